// File: rtl/spi_rx.sv
// SPI frame receiver: synchronizes sclk/cs/mosi into clk, samples mosi on sclk falls
// (LSB first) and presents each complete DATA_W-bit word on dout with a one-cycle done.
module spi_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   s_sclk, s_cs, s_mosi;
  logic                   s_sclk_d, s_cs_d;
  logic                   fall, cs_rise;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              word_pend;

  // cs synchronizer resets to the idle (deselected) level so reset never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      s_sclk_d  <= 1'b0;
      s_cs_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      s_sclk_d  <= s_sclk;
      s_cs_d    <= s_cs;
    end
  end

  assign s_sclk  = sclk_sync[SYNC_STAGES-1];
  assign s_cs    = cs_sync[SYNC_STAGES-1];
  assign s_mosi  = mosi_sync[SYNC_STAGES-1];
  assign fall    = s_sclk_d & ~s_sclk;
  assign cs_rise = ~s_cs_d & s_cs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      word_pend <= 1'b0;
      dout      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!s_cs) begin
            state <= RECV;
            cnt   <= '0;
            shreg <= '0;
            busy  <= 1'b1;
          end
        end
        RECV: begin
          // A cs rise in the same cycle as a fall aborts the frame and drops that bit.
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (fall) begin
            shreg <= {s_mosi, shreg[DATA_W-1:1]};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(DATA_W - 1)) begin
              state     <= WAIT_CS;
              word_pend <= 1'b1;
            end
          end
        end
        WAIT_CS: begin
          if (word_pend) begin
            dout      <= shreg;
            done      <= 1'b1;
            word_pend <= 1'b0;
          end
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
